// File: rtl/dm_pkg.sv
// dm_pkg: shared encodings for the data-memory access unit.
// Holds the DMCtrl size/sign codes, the access FSM state enum and the
// byte-enable base patterns that get shifted into position by the byte offset.
package dm_pkg;

  // DMCtrl access size/sign encodings
  localparam logic [2:0] DM_B  = 3'b000;
  localparam logic [2:0] DM_H  = 3'b001;
  localparam logic [2:0] DM_W  = 3'b010;
  localparam logic [2:0] DM_BU = 3'b100;
  localparam logic [2:0] DM_HU = 3'b101;

  // Byte-enable base patterns before shifting by the byte offset
  localparam logic [3:0] BE_B = 4'b0001;
  localparam logic [3:0] BE_H = 4'b0011;
  localparam logic [3:0] BE_W = 4'b1111;

  // Access FSM states; values are visible on the debug state port
  typedef enum logic [2:0] {
    IDLE = 3'd0,
    REQ0 = 3'd1,
    RSP0 = 3'd2,
    REQ1 = 3'd3,
    RSP1 = 3'd4
  } dm_state_e;

  // Base byte-enable pattern for a DMCtrl code; zero marks an unsupported code
  function automatic logic [3:0] dm_be_base(input logic [2:0] ctrl);
    case (ctrl)
      DM_B, DM_BU: dm_be_base = BE_B;
      DM_H, DM_HU: dm_be_base = BE_H;
      DM_W:        dm_be_base = BE_W;
      default:     dm_be_base = 4'b0000;
    endcase
  endfunction

endpackage

// File: rtl/dm_lane_align.sv
// dm_lane_align: combinational byte-lane logic for the access unit.
// Store side works on the live request (byte enables, shifted write data,
// misalignment and support flags). Load side works on the captured request
// and a 64-bit {beat1, beat0} window, extracting and extending the result.
module dm_lane_align
  import dm_pkg::*;
(
  input  logic [2:0]  i_ctrl,
  input  logic [1:0]  i_off,
  input  logic [31:0] i_wdata,
  input  logic [2:0]  i_ld_ctrl,
  input  logic [1:0]  i_ld_off,
  input  logic [63:0] i_rdata64,
  output logic [7:0]  o_be64,
  output logic [63:0] o_wdata64,
  output logic        o_misalign,
  output logic        o_supported,
  output logic [31:0] o_ld_data
);

  logic [3:0]  w_be_base;
  logic [31:0] w_ld_word;

  assign w_be_base   = dm_be_base(i_ctrl);
  assign o_be64      = {4'b0000, w_be_base} << i_off;
  assign o_wdata64   = {32'h0, i_wdata} << {i_off, 3'b000};
  // Any enable spilling into the upper word means a second beat is needed
  assign o_misalign  = |o_be64[7:4];
  assign o_supported = (w_be_base != 4'b0000);

  // Bring the addressed byte down to lane 0 of the two-word window
  assign w_ld_word = 32'(i_rdata64 >> {i_ld_off, 3'b000});

  // Truncate to the access size and sign- or zero-extend
  always_comb begin
    o_ld_data = 32'h0;
    case (i_ld_ctrl)
      DM_B:    o_ld_data = {{24{w_ld_word[7]}}, w_ld_word[7:0]};
      DM_H:    o_ld_data = {{16{w_ld_word[15]}}, w_ld_word[15:0]};
      DM_W:    o_ld_data = w_ld_word;
      DM_BU:   o_ld_data = {24'h0, w_ld_word[7:0]};
      DM_HU:   o_ld_data = {16'h0, w_ld_word[15:0]};
      default: o_ld_data = 32'h0;
    endcase
  end

endmodule

// File: rtl/dm_access_unit.sv
// dm_access_unit: load/store access unit between the core and a
// request/grant/rvalid word memory.
// Optional feature macro DM_MISALIGN_SPLIT_EN: when defined, accesses that
// cross a word boundary are split into two beats; when undefined they are
// rejected with a misalign_err pulse and no memory traffic.
//
// Handshake: the core's req is taken only while the unit is IDLE (busy=0);
// mem_req is held with stable mem_addr/mem_be/mem_wdata/mem_we until a cycle
// with mem_gnt=1 accepts the beat; mem_rvalid is only honoured in RSP0/RSP1;
// done is a one-cycle pulse with rdata valid alongside it.
module dm_access_unit
  import dm_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req,
  input  logic              DmWr,
  input  logic [2:0]        DMCtrl,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  output logic              busy,
  output logic              done,
  output logic [DATA_W-1:0] rdata,
  output logic              misalign_err,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [3:0]        mem_be,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic              mem_gnt,
  input  logic              mem_rvalid,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic [2:0]        dbg_state
);

`ifdef DM_MISALIGN_SPLIT_EN
  localparam bit SPLIT_EN = 1'b1;
`else
  localparam bit SPLIT_EN = 1'b0;
`endif

  dm_state_e         r_state;
  logic              r_we;
  logic              r_split;
  logic [2:0]        r_ctrl;
  logic [1:0]        r_off;
  logic [ADDR_W-1:0] r_addr_word;
  logic [3:0]        r_be_hi;
  logic [31:0]       r_wdata_hi;
  logic [31:0]       r_beat0;
  logic              r_done;
  logic              r_err;
  logic [31:0]       r_rdata;
  logic              r_mem_req;
  logic              r_mem_we;
  logic [ADDR_W-1:0] r_mem_addr;
  logic [3:0]        r_mem_be;
  logic [31:0]       r_mem_wdata;

  logic [ADDR_W-1:0] w_addr_word;
  logic [ADDR_W-1:0] w_addr_next;
  logic [7:0]        w_be64;
  logic [63:0]       w_wdata64;
  logic              w_misalign;
  logic              w_supported;
  logic              w_reject;
  logic [63:0]       w_rdata64;
  logic [31:0]       w_ld_data;

  assign w_addr_word = {addr[ADDR_W-1:2], 2'b00};
  // Second-beat address wraps naturally at the top of the address space
  assign w_addr_next = r_addr_word + ADDR_W'(4);
  // Requests that never reach memory: bad DMCtrl, or a split with splitting off
  assign w_reject    = !w_supported || (w_misalign && !SPLIT_EN);
  // Only the final beat of a split load pairs with the saved first word
  assign w_rdata64   = (r_state == RSP1) ? {mem_rdata, r_beat0} : {32'h0, mem_rdata};

  dm_lane_align u_lane_align (
    .i_ctrl      (DMCtrl),
    .i_off       (addr[1:0]),
    .i_wdata     (wdata),
    .i_ld_ctrl   (r_ctrl),
    .i_ld_off    (r_off),
    .i_rdata64   (w_rdata64),
    .o_be64      (w_be64),
    .o_wdata64   (w_wdata64),
    .o_misalign  (w_misalign),
    .o_supported (w_supported),
    .o_ld_data   (w_ld_data)
  );

  // Access FSM: captures the request, sequences one or two beats, pulses done
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= IDLE;
      r_we        <= 1'b0;
      r_split     <= 1'b0;
      r_ctrl      <= 3'b000;
      r_off       <= 2'b00;
      r_addr_word <= '0;
      r_be_hi     <= 4'b0000;
      r_wdata_hi  <= 32'h0;
      r_beat0     <= 32'h0;
      r_done      <= 1'b0;
      r_err       <= 1'b0;
      r_rdata     <= 32'h0;
      r_mem_req   <= 1'b0;
      r_mem_we    <= 1'b0;
      r_mem_addr  <= '0;
      r_mem_be    <= 4'b0000;
      r_mem_wdata <= 32'h0;
    end else begin
      r_done <= 1'b0;
      r_err  <= 1'b0;
      case (r_state)
        IDLE: begin
          if (req) begin
            r_we        <= DmWr;
            r_ctrl      <= DMCtrl;
            r_off       <= addr[1:0];
            r_addr_word <= w_addr_word;
            r_be_hi     <= w_be64[7:4];
            r_wdata_hi  <= w_wdata64[63:32];
            r_split     <= w_misalign;
            if (w_reject) begin
              r_done  <= 1'b1;
              r_err   <= w_misalign && !SPLIT_EN;
              r_rdata <= 32'h0;
            end else begin
              r_state     <= REQ0;
              r_mem_req   <= 1'b1;
              r_mem_we    <= DmWr;
              r_mem_addr  <= w_addr_word;
              r_mem_be    <= w_be64[3:0];
              r_mem_wdata <= w_wdata64[31:0];
            end
          end
        end
        REQ0: begin
          if (mem_gnt) begin
            if (r_we && r_split) begin
              r_state     <= REQ1;
              r_mem_addr  <= w_addr_next;
              r_mem_be    <= r_be_hi;
              r_mem_wdata <= r_wdata_hi;
            end else if (r_we) begin
              r_state   <= IDLE;
              r_mem_req <= 1'b0;
              r_mem_we  <= 1'b0;
              r_mem_be  <= 4'b0000;
              r_done    <= 1'b1;
              r_rdata   <= 32'h0;
            end else begin
              r_state   <= RSP0;
              r_mem_req <= 1'b0;
            end
          end
        end
        RSP0: begin
          if (mem_rvalid) begin
            if (r_split) begin
              r_beat0    <= mem_rdata;
              r_state    <= REQ1;
              r_mem_req  <= 1'b1;
              r_mem_addr <= w_addr_next;
              r_mem_be   <= r_be_hi;
            end else begin
              r_state  <= IDLE;
              r_mem_be <= 4'b0000;
              r_done   <= 1'b1;
              r_rdata  <= w_ld_data;
            end
          end
        end
        REQ1: begin
          if (mem_gnt) begin
            r_mem_req <= 1'b0;
            if (r_we) begin
              r_state  <= IDLE;
              r_mem_we <= 1'b0;
              r_mem_be <= 4'b0000;
              r_done   <= 1'b1;
              r_rdata  <= 32'h0;
            end else begin
              r_state <= RSP1;
            end
          end
        end
        RSP1: begin
          if (mem_rvalid) begin
            r_state  <= IDLE;
            r_mem_be <= 4'b0000;
            r_done   <= 1'b1;
            r_rdata  <= w_ld_data;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign busy         = (r_state != IDLE);
  assign done         = r_done;
  assign misalign_err = r_err;
  assign rdata        = r_rdata;
  assign mem_req      = r_mem_req;
  assign mem_we       = r_mem_we;
  assign mem_addr     = r_mem_addr;
  assign mem_be       = r_mem_be;
  assign mem_wdata    = r_mem_wdata;
  assign dbg_state    = r_state;

endmodule

// File: doc/dm_access_unit.md
DM_ACCESS_UNIT -- requirements
Module: dm_access_unit

Interface
REQ-001 The block SHALL provide parameter ADDR_W, default 32, meaning the byte-address width.
REQ-002 The block SHALL provide parameter DATA_W, default 32, meaning the word width; only 32 is supported.
REQ-003 The block SHALL have a single clock and a synchronous, active-high reset.
REQ-004 The block SHALL have these ports:
- clk  in  1  clock.
- rst  in  1  synchronous active-high reset.
- req  in  1  core access request.
- DmWr  in  1  1=store, 0=load.
- DMCtrl  in  3  access size/sign: 000 B, 001 H, 010 W, 100 BU, 101 HU.
- addr  in  ADDR_W  byte address from the ALU.
- wdata  in  32  store data from the register file.
- busy  out  1  access in progress, core stalls.
- done  out  1  one-cycle completion pulse.
- rdata  out  32  extended load result, valid while done=1.
- misalign_err  out  1  one-cycle error pulse, coincident with done.
- mem_req  out  1  memory beat request.
- mem_we  out  1  memory write.
- mem_addr  out  ADDR_W  word-aligned address (bits 1:0 = 0).
- mem_be  out  4  byte enables.
- mem_wdata  out  32  lane-aligned write data.
- mem_gnt  in  1  memory accepted beat.
- mem_rvalid  in  1  read data valid.
- mem_rdata  in  32  read word.

Function
REQ-005 The block SHALL accept req only in IDLE; req while busy=1 SHALL be ignored, and the inputs SHALL be registered at acceptance.
REQ-006 The FSM SHALL have states IDLE, REQ0, RSP0, REQ1, RSP1; busy SHALL be 1 in every state except IDLE.
REQ-007 Transitions SHALL be:
- IDLE→REQ0 on accept.
- REQx→RSPx on mem_gnt for a load.
- REQ0→REQ1 on mem_gnt for a split store.
- RSP0→REQ1 on mem_rvalid for a split load.
- Completion SHALL return the FSM to IDLE: gnt of the last store beat, or rvalid of the last load beat.
REQ-008 mem_req SHALL be 1 only in REQ0/REQ1 and SHALL be held with stable mem_addr/mem_be/mem_wdata until mem_gnt.
REQ-009 Byte enables SHALL be be64 = {B:0001, H:0011, W:1111} << off, where off=addr[1:0]; beat0 SHALL use be64[3:0] and beat1 SHALL use be64[7:4].
REQ-010 Write data SHALL be the 64-bit value wdata << (8*off); beat0 SHALL drive the low word and beat1 SHALL drive the high word.
REQ-011 An access SHALL be misaligned when be64[7:4]≠0, i.e. H with off=3 or W with off≠0.
REQ-012 Beat1 address SHALL be (addr & ~3)+4, modulo 2^ADDR_W, so 0xFFFFFFFE wraps to 0x00000000.
REQ-013 Load data SHALL be {beat1_word, beat0_word} >> (8*off), truncated to size and then sign- or zero-extended per DMCtrl.
REQ-014 done SHALL be registered, asserting the cycle after completion while the state is IDLE; rdata SHALL be 0 for stores.
REQ-015 Minimum latency SHALL be: accept at cycle 0, mem_req in cycle 1, done in cycle 2 (aligned store with immediate gnt), or done in cycle 3 (aligned load with rvalid in cycle 2).
REQ-016 Unsupported DMCtrl (011, 110, 111) SHALL issue no beat and SHALL pulse done with rdata=0 in cycle 1.
REQ-017 mem_rvalid outside RSP0/RSP1 SHALL be ignored.

Reset
REQ-018 On rst, the state SHALL go to IDLE and busy, done, misalign_err, mem_req, mem_we and mem_be SHALL be 0; rdata, mem_addr and mem_wdata SHALL be 0.
REQ-019 Reset mid-operation SHALL drop mem_req in the cycle after the reset edge, SHALL produce no done pulse, and SHALL ignore any later mem_rvalid.

Configuration
REQ-020 With macro DM_MISALIGN_SPLIT_EN defined, misaligned accesses SHALL be split into two beats per REQ-007..013 and misalign_err SHALL stay 0.
REQ-021 Without DM_MISALIGN_SPLIT_EN, a misaligned access SHALL issue no beat, SHALL pulse done and misalign_err in cycle 1 with rdata=0, and states REQ1/RSP1 SHALL be unreachable.

Structure
REQ-022 Package dm_pkg SHALL hold the DMCtrl encodings (DM_B, DM_H, DM_W, DM_BU, DM_HU), the FSM state enum and the be base patterns.
REQ-023 Sub-module dm_lane_align SHALL implement the combinational byte-enable/shift generation and load extraction/extension.

Verification
REQ-024 The bench SHALL cover these scenarios:
- SB addr=0x103 with wdata=0xAB, gnt immediate -> mem_addr=0x100, be=1000, mem_wdata=0xAB000000, done in cycle 2.
- LH addr=0x102 with mem_rdata=0x8001xxxx -> rdata=0xFFFF8001; LHU with the same data -> rdata=0x00008001.
- LW addr=0x201 (split enabled), beat0 data=0x44332211 and beat1 data=0x88776655 -> beat addresses 0x200 then 0x204, be 1110 then 0001, rdata=0x55443322.
- SW addr=0xFFFFFFFE (split enabled) -> beat1 mem_addr=0x00000000, be=0011; without the macro -> no mem_req, misalign_err=1 with done.
- mem_gnt held low for 5 cycles -> mem_req and its fields stay stable, busy=1, a second req is ignored.
- rst asserted in RSP0 -> state IDLE and busy=0 next cycle, and a late mem_rvalid produces no done.
